// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix row/column lines plus the decoded key outputs.
// The scanner uses the slave modport; the keypad/consumer side uses master.
interface keypad_scanner_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       shift;
    logic       key_valid;
    logic       key_held;

    modport master (output col, input row, key, shift, key_valid, key_held);
    modport slave  (input col, output row, key, shift, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column sync, tick-based debounce, key decode.
// Optional auto-repeat of held digit keys is enabled by defining TYPEMATIC_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned REPEAT_DLY   = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic            clock,
    input  logic            reset,
    keypad_scanner_if.slave kp
);
    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [3:0]         sync1, csync;
    logic [TICK_W-1:0]  tick_cnt;
    logic [1:0]         row_idx, row_idx_n;
    logic [1:0]         col_idx, col_idx_n;
    logic [DEB_W-1:0]   deb_cnt, deb_cnt_n;
    logic               lockout, lockout_n;
    logic [1:0]         clr_cnt, clr_cnt_n;
    logic [3:0]         row_q, row_n;
    logic [3:0]         key_q, key_n;
    logic               shift_q, shift_n;
    logic               key_valid_q, key_valid_n;
    logic               key_held_q, key_held_n;

    logic               tick_c;
    logic [2:0]         low_cnt_c;
    logic [1:0]         low_idx_c;
    logic               one_low_c, all_high_c, same_col_c;
    logic [3:0]         code_c;
    logic               accept_c;
    logic               rep_fire_c;

    // Keypad layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:  key_code = 4'd1;
            4'd1:  key_code = 4'd2;
            4'd2:  key_code = 4'd3;
            4'd3:  key_code = 4'd10;
            4'd4:  key_code = 4'd4;
            4'd5:  key_code = 4'd5;
            4'd6:  key_code = 4'd6;
            4'd7:  key_code = 4'd11;
            4'd8:  key_code = 4'd7;
            4'd9:  key_code = 4'd8;
            4'd10: key_code = 4'd9;
            4'd11: key_code = 4'd12;
            4'd12: key_code = 4'd14;
            4'd13: key_code = 4'd0;
            4'd14: key_code = 4'd15;
            4'd15: key_code = 4'd13;
        endcase
    endfunction

    assign tick_c = (tick_cnt == TICK_LAST);

    // Column summary of the synchronised sense lines
    always_comb begin
        low_cnt_c = 3'd0;
        low_idx_c = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!csync[i]) begin
                low_cnt_c = low_cnt_c + 3'd1;
                low_idx_c = 2'(i);
            end
        end
    end

    assign one_low_c  = (low_cnt_c == 3'd1);
    assign all_high_c = (csync == 4'hF);
    assign same_col_c = one_low_c && (low_idx_c == col_idx);
    assign code_c     = key_code({row_idx, low_idx_c});

`ifdef TYPEMATIC_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_n;
    logic             rep_run, rep_run_n;

    // Repeat timer runs only in HELD while the captured digit stays down
    always_comb begin
        rep_cnt_n  = rep_cnt;
        rep_run_n  = rep_run;
        rep_fire_c = 1'b0;
        if (state != S_HELD) begin
            rep_cnt_n = '0;
            rep_run_n = 1'b0;
        end else if (tick_c) begin
            if (!csync[col_idx] && key_q <= 4'd9) begin
                if (rep_cnt + REP_W'(1) == (rep_run ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DLY))) begin
                    rep_fire_c = 1'b1;
                    rep_cnt_n  = '0;
                    rep_run_n  = 1'b1;
                end else begin
                    rep_cnt_n = rep_cnt + REP_W'(1);
                end
            end else begin
                rep_cnt_n = '0;
                rep_run_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_cnt <= '0;
            rep_run <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt_n;
            rep_run <= rep_run_n;
        end
    end
`else
    assign rep_fire_c = 1'b0;
`endif

    // Next-state and output decode; everything advances only on a scan tick
    always_comb begin
        state_n     = state;
        row_idx_n   = row_idx;
        col_idx_n   = col_idx;
        deb_cnt_n   = deb_cnt;
        lockout_n   = lockout;
        clr_cnt_n   = clr_cnt;
        key_n       = key_q;
        shift_n     = 1'b0;
        key_valid_n = 1'b0;
        key_held_n  = key_held_q;
        accept_c    = 1'b0;

        if (tick_c) begin
            unique case (state)
                S_SCAN: begin
                    if (one_low_c && !lockout) begin
                        col_idx_n = low_idx_c;
                        deb_cnt_n = DEB_ONE;
                        if (DEB_ONE == DEB_TARGET) accept_c = 1'b1;
                        else                       state_n  = S_DEBOUNCE;
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                        // After a release, keys pressed meanwhile stay locked out
                        // until one full sweep sees every row clear.
                        if (lockout) begin
                            if (!all_high_c) begin
                                clr_cnt_n = 2'd0;
                            end else if (clr_cnt == 2'd3) begin
                                lockout_n = 1'b0;
                                clr_cnt_n = 2'd0;
                            end else begin
                                clr_cnt_n = clr_cnt + 2'd1;
                            end
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (same_col_c) begin
                        deb_cnt_n = deb_cnt + DEB_ONE;
                        if (deb_cnt + DEB_ONE == DEB_TARGET) accept_c = 1'b1;
                    end else begin
                        deb_cnt_n = '0;
                        state_n   = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (all_high_c) begin
                        if (deb_cnt + DEB_ONE == DEB_TARGET) begin
                            deb_cnt_n  = '0;
                            key_held_n = 1'b0;
                            row_idx_n  = row_idx + 2'd1;
                            lockout_n  = 1'b1;
                            clr_cnt_n  = 2'd0;
                            state_n    = S_SCAN;
                        end else begin
                            deb_cnt_n = deb_cnt + DEB_ONE;
                        end
                    end else begin
                        deb_cnt_n = '0;
                    end
                    if (rep_fire_c) begin
                        key_valid_n = 1'b1;
                        shift_n     = 1'b1;
                    end
                end
                default: state_n = S_SCAN;
            endcase
        end

        if (accept_c) begin
            key_n       = code_c;
            key_valid_n = 1'b1;
            shift_n     = (code_c <= 4'd9);
            key_held_n  = 1'b1;
            deb_cnt_n   = '0;
            state_n     = S_HELD;
        end

        row_n = ~(4'b0001 << row_idx_n);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_SCAN;
            sync1       <= 4'hF;
            csync       <= 4'hF;
            tick_cnt    <= '0;
            row_idx     <= 2'd0;
            col_idx     <= 2'd0;
            deb_cnt     <= '0;
            lockout     <= 1'b0;
            clr_cnt     <= 2'd0;
            row_q       <= 4'b1110;
            key_q       <= 4'd0;
            shift_q     <= 1'b0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state       <= state_n;
            sync1       <= kp.col;
            csync       <= sync1;
            tick_cnt    <= tick_c ? '0 : tick_cnt + TICK_W'(1);
            row_idx     <= row_idx_n;
            col_idx     <= col_idx_n;
            deb_cnt     <= deb_cnt_n;
            lockout     <= lockout_n;
            clr_cnt     <= clr_cnt_n;
            row_q       <= row_n;
            key_q       <= key_n;
            shift_q     <= shift_n;
            key_valid_q <= key_valid_n;
            key_held_q  <= key_held_n;
        end
    end

    assign kp.row       = row_q;
    assign kp.key       = key_q;
    assign kp.shift     = shift_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule
